// File: rtl/bus_trace_fifo.sv
//============================================================================
// Module   : bus_trace_fifo
// Purpose  : Capture buffer for the processor data bus. Samples bus_in while
//            capture is armed into a circular FIFO drained over valid/ready.
//            Keeps a sticky overflow flag and a saturating drop counter.
// Option   : TRACE_DEDUP_EN - when defined, only samples that differ from
//            the last pushed value are eligible for capture.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module bus_trace_fifo #(
  parameter int word_size = 8,
  parameter int ptr_size  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_size-1:0]  bus_in,
  input  logic                  capture_en,
  input  logic                  stop_on_full,
  input  logic                  clear,
  output logic [word_size-1:0]  dout,
  output logic                  valid,
  input  logic                  ready,
  output logic [ptr_size:0]     count,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  output logic                  halted
);

  localparam int                DEPTH     = 2 ** ptr_size;
  localparam logic [ptr_size:0] C_FULL    = (ptr_size + 1)'(DEPTH);
  localparam logic [7:0]        C_DROPMAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   halted_q;
  logic [ptr_size-1:0]    wp_q;
  logic [ptr_size-1:0]    rp_q;
  logic [ptr_size:0]      count_q;
  logic                   overflow_q;
  logic [7:0]             drop_q;
  logic [word_size-1:0]   mem_q [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_eligible;
  logic w_pop;
  logic w_push;
  logic w_blocked;

  assign w_full  = (count_q == C_FULL);
  assign w_empty = (count_q == '0);
  assign w_pop   = !w_empty && ready;

`ifdef TRACE_DEDUP_EN
  logic [word_size-1:0] last_q;
  logic                 last_vld_q;

  // A repeated bus value is not worth storing; the first one after a flush is.
  assign w_eligible = !last_vld_q || (bus_in != last_q);

  // Remember the most recently stored sample; dropped samples do not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (clear) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (w_push) begin
      last_q     <= bus_in;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign w_eligible = 1'b1;
`endif

  // A concurrent pop frees a slot, so a full FIFO still accepts the sample.
  assign w_push    = (state_q == S_RUN) && w_eligible && (!w_full || w_pop);
  // Sample arrives at a full FIFO with nothing leaving: drop it or halt.
  assign w_blocked = (state_q == S_RUN) && w_eligible && w_full && !w_pop;

  // Sample storage; not reset, contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      mem_q[wp_q] <= bus_in;
    end
  end

  // Capture FSM with registered halted flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
    end else if (clear) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (capture_en) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_blocked && stop_on_full) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (!capture_en) begin
            state_q <= S_IDLE;
          end
        end
        S_HALT: begin
          // Only clear or reset leaves HALT; draining does not resume capture.
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= S_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clear) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (w_push) begin
        wp_q <= wp_q + 1'b1;
      end
      if (w_pop) begin
        rp_q <= rp_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (w_blocked && !stop_on_full) begin
        overflow_q <= 1'b1;
        if (drop_q != C_DROPMAX) begin
          drop_q <= drop_q + 1'b1;
        end
      end
    end
  end

  // First-word fall-through: head entry is always presented.
  assign dout       = mem_q[rp_q];
  assign valid      = !w_empty;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign halted     = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_trace_fifo.sv
//============================================================================
// Module   : tb_bus_trace_fifo
// Purpose  : Directed self-checking bench for bus_trace_fifo.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_bus_trace_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic       capture_en;
  logic       stop_on_full;
  logic       clear;
  logic [7:0] dout;
  logic       valid;
  logic       ready;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] drop_count;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;

  bus_trace_fifo #(.word_size(8), .ptr_size(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_in       (bus_in),
    .capture_en   (capture_en),
    .stop_on_full (stop_on_full),
    .clear        (clear),
    .dout         (dout),
    .valid        (valid),
    .ready        (ready),
    .count        (count),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_in = 8'h00; capture_en = 1'b0; stop_on_full = 1'b0;
    clear = 1'b0; ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_valid",    32'(valid),      32'd0);
    chk("rst_count",    32'(count),      32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_drop",     32'(drop_count), 32'd0);
    chk("rst_halted",   32'(halted),     32'd0);
    rst = 1'b0;
    step();

    // Basic capture and drain: enable edge, then three sampled edges
    capture_en = 1'b1;
    step();
    chk("t1_arm_count", 32'(count), 32'd0);
    bus_in = 8'h10; step();
    chk("t1_first_valid", 32'(valid), 32'd1);
    chk("t1_first_dout",  32'(dout),  32'h10);
    bus_in = 8'h11; step();
    bus_in = 8'h12; capture_en = 1'b0; step();
    step();
    chk("t1_count3", 32'(count), 32'd3);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_dout",  32'(dout),  32'(8'h10 + i));
      chk("t1_count", 32'(count), 32'(3 - i));
      step();
    end
    chk("t1_valid_end", 32'(valid), 32'd0);
    chk("t1_count_end", 32'(count), 32'd0);
    ready = 1'b0;

    // Overflow without halt: 20 samples into 16 entries
    stop_on_full = 1'b0;
    capture_en = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      bus_in = 8'(8'h20 + i);
      capture_en = (i != 19);
      step();
    end
    chk("t2_count",    32'(count),      32'd16);
    chk("t2_overflow", 32'(overflow),   32'd1);
    chk("t2_drop",     32'(drop_count), 32'd4);
    chk("t2_halted",   32'(halted),     32'd0);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_dout", 32'(dout), 32'(8'h20 + i));
      step();
    end
    chk("t2_valid_end", 32'(valid), 32'd0);
    ready = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    chk("t2_clr_overflow", 32'(overflow),   32'd0);
    chk("t2_clr_drop",     32'(drop_count), 32'd0);

    // Halt at full: 17 samples with stop_on_full
    stop_on_full = 1'b1;
    capture_en = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      bus_in = 8'(8'h40 + i);
      step();
    end
    chk("t3_halted",   32'(halted),     32'd1);
    chk("t3_drop",     32'(drop_count), 32'd0);
    chk("t3_overflow", 32'(overflow),   32'd0);
    chk("t3_count",    32'(count),      32'd16);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_in = 8'(8'hE0 + i);
      chk("t3_dout", 32'(dout), 32'(8'h40 + i));
      step();
    end
    step(); step();
    chk("t3_drained_count",  32'(count),  32'd0);
    chk("t3_still_halted",   32'(halted), 32'd1);
    capture_en = 1'b0; ready = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    chk("t3_clr_halted", 32'(halted), 32'd0);
    chk("t3_clr_count",  32'(count),  32'd0);

    // Full FIFO with concurrent push/pop for 40 cycles, through pointer wrap
    stop_on_full = 1'b1;
    capture_en = 1'b1;
    step();
    for (int i = 0; i < 56; i++) begin
      bus_in = 8'(8'h60 + i);
      ready = (i >= 16);
      capture_en = (i != 55);
      if (i >= 16) begin
        chk("t4_dout",  32'(dout),  32'(8'h60 + i - 16));
        chk("t4_count", 32'(count), 32'd16);
      end
      step();
    end
    ready = 1'b0;
    chk("t4_count_end", 32'(count),      32'd16);
    chk("t4_halted",    32'(halted),     32'd0);
    chk("t4_drop",      32'(drop_count), 32'd0);
    chk("t4_overflow",  32'(overflow),   32'd0);
    ready = 1'b1;
    for (int i = 40; i < 56; i++) begin
      chk("t4_tail_dout", 32'(dout), 32'(8'h60 + i));
      step();
    end
    ready = 1'b0;
    chk("t4_valid_end", 32'(valid), 32'd0);

    // Asynchronous reset between edges with 5 stored entries
    capture_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bus_in = 8'(8'hA0 + i);
      capture_en = (i != 4);
      step();
    end
    chk("t5_count_pre", 32'(count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid",    32'(valid),    32'd0);
    chk("t5_async_count",    32'(count),    32'd0);
    chk("t5_async_overflow", 32'(overflow), 32'd0);
    step();
    rst = 1'b0;
    step();

`ifdef TRACE_DEDUP_EN
    // Repeated bus values collapse to one entry each
    capture_en = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      bus_in = (i >= 5 && i < 8) ? 8'hBB : 8'hAA;
      capture_en = (i != 8);
      step();
    end
    chk("t6_count", 32'(count), 32'd3);
    ready = 1'b1;
    chk("t6_dout0", 32'(dout), 32'hAA); step();
    chk("t6_dout1", 32'(dout), 32'hBB); step();
    chk("t6_dout2", 32'(dout), 32'hAA); step();
    chk("t6_valid_end", 32'(valid), 32'd0);
    ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
